// File: rtl/debounced_button_array.sv
// Multi-channel 2-flop synchroniser + dual-edge debouncer with level, rise/fall pulses.
// Define AUTO_REPEAT_EN to add hold-to-repeat pulses on rpt; otherwise rpt is tied low.
module debounced_button_array #(
  parameter int unsigned NUM_CH               = 4,
  parameter int unsigned DEBOUNCE_CYCLES      = 1_000_000,
  parameter int unsigned REPEAT_DELAY_CYCLES  = 50_000_000,
  parameter int unsigned REPEAT_PERIOD_CYCLES = 10_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] pin,
  output logic [NUM_CH-1:0] level,
  output logic [NUM_CH-1:0] rise,
  output logic [NUM_CH-1:0] fall,
  output logic [NUM_CH-1:0] rpt,
  output logic              any_rise
);

  function automatic int unsigned max_of(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

`ifdef AUTO_REPEAT_EN
  localparam int unsigned MAX_CYC =
    max_of(max_of(DEBOUNCE_CYCLES, REPEAT_DELAY_CYCLES), REPEAT_PERIOD_CYCLES);
`else
  localparam int unsigned MAX_CYC = DEBOUNCE_CYCLES;
`endif
  localparam int unsigned CW = $clog2(MAX_CYC) + 1;
  localparam logic [CW-1:0] DB_LOAD = CW'(DEBOUNCE_CYCLES - 1);
`ifdef AUTO_REPEAT_EN
  localparam logic [CW-1:0] RD_LOAD = CW'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [CW-1:0] RP_LOAD = CW'(REPEAT_PERIOD_CYCLES - 1);
`endif

  typedef enum logic [1:0] {
    S_LOW,
    S_RISE_WAIT,
    S_HIGH,
    S_FALL_WAIT
  } state_t;

  logic [NUM_CH-1:0] sync1;
  logic [NUM_CH-1:0] s;

  state_t            state     [NUM_CH];
  state_t            state_nxt [NUM_CH];
  logic [CW-1:0]     cnt       [NUM_CH];
  logic [CW-1:0]     cnt_nxt   [NUM_CH];
  logic [NUM_CH-1:0] level_nxt;
  logic [NUM_CH-1:0] rise_nxt;
  logic [NUM_CH-1:0] fall_nxt;
`ifdef AUTO_REPEAT_EN
  logic [CW-1:0]     rcnt      [NUM_CH];
  logic [CW-1:0]     rcnt_nxt  [NUM_CH];
  logic [NUM_CH-1:0] rpt_nxt;
`endif

  always_comb begin
    level_nxt = level;
    rise_nxt  = '0;
    fall_nxt  = '0;
`ifdef AUTO_REPEAT_EN
    rpt_nxt   = '0;
`endif
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      state_nxt[i] = state[i];
      cnt_nxt[i]   = cnt[i];
`ifdef AUTO_REPEAT_EN
      rcnt_nxt[i]  = rcnt[i];
`endif
      case (state[i])
        S_LOW: begin
          if (s[i]) begin
            state_nxt[i] = S_RISE_WAIT;
            cnt_nxt[i]   = DB_LOAD;
          end
        end
        S_RISE_WAIT: begin
          if (!s[i]) begin
            state_nxt[i] = S_LOW;
          end else if (cnt[i] != '0) begin
            cnt_nxt[i] = cnt[i] - CW'(1);
          end else begin
            state_nxt[i] = S_HIGH;
            level_nxt[i] = 1'b1;
            rise_nxt[i]  = 1'b1;
`ifdef AUTO_REPEAT_EN
            rcnt_nxt[i]  = RD_LOAD;
`endif
          end
        end
        S_HIGH: begin
          // A release takes priority over a repeat falling due in the same cycle.
          if (!s[i]) begin
            state_nxt[i] = S_FALL_WAIT;
            cnt_nxt[i]   = DB_LOAD;
          end
`ifdef AUTO_REPEAT_EN
          else if (rcnt[i] == '0) begin
            rpt_nxt[i]  = 1'b1;
            rcnt_nxt[i] = RP_LOAD;
          end else begin
            rcnt_nxt[i] = rcnt[i] - CW'(1);
          end
`endif
        end
        S_FALL_WAIT: begin
          if (s[i]) begin
            state_nxt[i] = S_HIGH;
`ifdef AUTO_REPEAT_EN
            rcnt_nxt[i]  = RD_LOAD;
`endif
          end else if (cnt[i] != '0) begin
            cnt_nxt[i] = cnt[i] - CW'(1);
          end else begin
            state_nxt[i] = S_LOW;
            level_nxt[i] = 1'b0;
            fall_nxt[i]  = 1'b1;
          end
        end
        default: state_nxt[i] = S_LOW;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1    <= '0;
      s        <= '0;
      level    <= '0;
      rise     <= '0;
      fall     <= '0;
      any_rise <= 1'b0;
`ifdef AUTO_REPEAT_EN
      rpt      <= '0;
`endif
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        state[i] <= S_LOW;
        cnt[i]   <= '0;
`ifdef AUTO_REPEAT_EN
        rcnt[i]  <= '0;
`endif
      end
    end else begin
      sync1    <= pin;
      s        <= sync1;
      level    <= level_nxt;
      rise     <= rise_nxt;
      fall     <= fall_nxt;
      any_rise <= |rise_nxt;
`ifdef AUTO_REPEAT_EN
      rpt      <= rpt_nxt;
`endif
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        state[i] <= state_nxt[i];
        cnt[i]   <= cnt_nxt[i];
`ifdef AUTO_REPEAT_EN
        rcnt[i]  <= rcnt_nxt[i];
`endif
      end
    end
  end

`ifndef AUTO_REPEAT_EN
  assign rpt = '0;
`endif

endmodule
